mem_stage: RTL

- Memory-access pipeline stage. Sits between exe_stage and wb_stage; consumes exe_stage's ES→MS bus and data-SRAM read data.
- Aligns and extends load data for lb/lbu/lh/lhu/lw/lwl/lwr and produces per-byte register write enables so wb_stage can merge lwl/lwr.
- Drives the MS→WS bus and the MEM-stage forward/block bus used by decode.

---
 rtl/mem_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : MEM pipeline stage - load alignment, per-byte write enables,
//             MS->WS bus and MEM forward/block bus for decode.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int ES_TO_MS_BUS_WD   = 78,
  parameter int MS_TO_WS_BUS_WD   = 73,
  parameter int MS_FWD_BLK_BUS_WD = 42
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ws_allowin,
  output logic                         ms_allowin,
  input  logic                         es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  input  logic [31:0]                  data_sram_rdata,
  output logic                         ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
  output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus
);

  logic                       ms_valid_q;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_q;
  logic                       rdata_held_q;
  logic [31:0]                rdata_buf_q;
  logic                       ms_ready_go;

  logic        op_lb, op_lbu, op_lh, op_lhu, op_lw, op_lwl, op_lwr;
  logic        res_from_mem, gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result, pc;
  logic [1:0]  addr_lo;

  logic [31:0] rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_res;
  logic [3:0]  load_we;
  logic [31:0] final_result;
  logic [3:0]  rf_we;

  assign {op_lb, op_lbu, op_lh, op_lhu, op_lw, op_lwl, op_lwr,
          res_from_mem, gr_we, dest, exe_result, pc} = ms_bus_q;
  assign addr_lo = exe_result[1:0];

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_q <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus_q <= es_to_ms_bus;
    end
  end

  // SRAM data is only valid in the first MEM cycle; hold it across a stall.
  always_ff @(posedge clk) begin
    if (reset || ms_allowin) begin
      rdata_held_q <= 1'b0;
    end else if (ms_valid_q && !rdata_held_q && !ws_allowin) begin
      rdata_held_q <= 1'b1;
      rdata_buf_q  <= data_sram_rdata;
    end
  end

  assign rdata = rdata_held_q ? rdata_buf_q : data_sram_rdata;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_res = rdata;
    load_we  = 4'b1111;
    if (op_lb) begin
      load_res = {{24{byte_sel[7]}}, byte_sel};
    end else if (op_lbu) begin
      load_res = {24'b0, byte_sel};
    end else if (op_lh) begin
      load_res = {{16{half_sel[15]}}, half_sel};
    end else if (op_lhu) begin
      load_res = {16'b0, half_sel};
    end else if (op_lwl) begin
      case (addr_lo)
        2'd0: begin load_res = {rdata[7:0], 24'b0};  load_we = 4'b1000; end
        2'd1: begin load_res = {rdata[15:0], 16'b0}; load_we = 4'b1100; end
        2'd2: begin load_res = {rdata[23:0], 8'b0};  load_we = 4'b1110; end
        default: begin load_res = rdata;             load_we = 4'b1111; end
      endcase
    end else if (op_lwr) begin
      case (addr_lo)
        2'd0: begin load_res = rdata;                 load_we = 4'b1111; end
        2'd1: begin load_res = {8'b0, rdata[31:8]};   load_we = 4'b0111; end
        2'd2: begin load_res = {16'b0, rdata[31:16]}; load_we = 4'b0011; end
        default: begin load_res = {24'b0, rdata[31:24]}; load_we = 4'b0001; end
      endcase
    end else if (op_lw) begin
      load_res = rdata;
    end
  end

  always_comb begin
    if (res_from_mem) begin
      final_result = load_res;
      rf_we        = gr_we ? load_we : 4'b0000;
    end else begin
      final_result = exe_result;
      rf_we        = {4{gr_we}};
    end
  end

  assign ms_to_ws_bus   = {rf_we, dest, final_result, pc};
  // Loads resolve here, so decode never needs to block on this stage.
  assign ms_fwd_blk_bus = {{4{ms_valid_q}} & rf_we, dest, final_result, 1'b0};

endmodule

`default_nettype wire
